// File: rtl/lms_input_align_pkg.sv
// rtl/lms_input_align_pkg.sv - shared widths, state encoding and helpers for the LMS input aligner
package lms_input_align_pkg;

  localparam int SAMP_W_DEF  = 32;
  localparam int FIFO_AW_DEF = 4;
  localparam int PAIR_W      = 2 * SAMP_W_DEF;
  // main sideband: timestamp, has_time, length, eov, eob
  localparam int SB_W        = 64 + 1 + 16 + 1 + 1;
  localparam int MAIN_ENT_W  = SAMP_W_DEF + 1 + SB_W;

  typedef enum logic [1:0] {
    ST_PAIR        = 2'd0,
    ST_DISCARD_AUX = 2'd1,
    ST_PAD_MAIN    = 2'd2
  } align_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lms_input_align_if.sv
// rtl/lms_input_align_if.sv - sample stream with main-style sideband, shared by inputs and the paired output
interface lms_input_align_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic [63:0]       ttimestamp;
  logic              thas_time;
  logic [15:0]       tlength;
  logic              teov;
  logic              teob;

  modport master (
    output tdata, tlast, tvalid, ttimestamp, thas_time, tlength, teov, teob,
    input  tready
  );

  modport slave (
    input  tdata, tlast, tvalid, ttimestamp, thas_time, tlength, teov, teob,
    output tready
  );
endinterface

// File: rtl/lms_align_fifo.sv
// rtl/lms_align_fifo.sv - synchronous FIFO with registered ready, first-word-fall-through head
module lms_align_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_rd_pop,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push      = i_wr_valid & r_ready;
  assign w_pop       = i_rd_pop & (r_count != '0);
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // ready is registered from the next count so a pop in the full cycle reopens it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != DEPTH);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_wr_ready = r_ready;
  assign o_rd_data  = r_mem[r_rptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == DEPTH);
  assign o_count    = r_count;

endmodule

// File: rtl/lms_input_align.sv
// rtl/lms_input_align.sv - pairs main (x) and aux (d) samples one-to-one with packet-boundary recovery
module lms_input_align
  import lms_input_align_pkg::*;
#(
  parameter int SAMP_W  = SAMP_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst,
  lms_input_align_if.slave  s_main_axis,
  lms_input_align_if.slave  s_aux_axis,
  lms_input_align_if.master m_pair_axis,
  input  logic              clear_cnt,
  output logic [15:0]       mismatch_cnt,
  output logic              pad_active
);
  localparam int MAIN_W = SAMP_W + 1 + SB_W;
  localparam int AUX_W  = SAMP_W + 1;

  align_state_t      r_state;
  align_state_t      w_state_nxt;
  logic [15:0]       r_mismatch_cnt;
  logic [MAIN_W-1:0] w_main_head;
  logic [AUX_W-1:0]  w_aux_head;
  logic              w_main_empty, w_aux_empty, w_main_full, w_aux_full;
  logic [FIFO_AW:0]  w_main_count, w_aux_count;
  logic              w_pop_main, w_pop_aux, w_inc, w_pad, w_valid, w_fire;
  logic [SAMP_W-1:0] w_main_data, w_aux_data, w_aux_half;
  logic              w_main_last, w_aux_last;
  logic [63:0]       w_ts;
  logic              w_has_time, w_eov, w_eob;
  logic [15:0]       w_len;
  logic              w_unused_sigs;

  lms_align_fifo #(.WIDTH(MAIN_W), .AW(FIFO_AW)) u_main_fifo (
    .i_clk      (axis_data_clk),
    .i_rst      (axis_data_rst),
    .i_wr_data  ({s_main_axis.tdata, s_main_axis.tlast, s_main_axis.ttimestamp,
                  s_main_axis.thas_time, s_main_axis.tlength, s_main_axis.teov, s_main_axis.teob}),
    .i_wr_valid (s_main_axis.tvalid),
    .o_wr_ready (s_main_axis.tready),
    .o_rd_data  (w_main_head),
    .i_rd_pop   (w_pop_main),
    .o_empty    (w_main_empty),
    .o_full     (w_main_full),
    .o_count    (w_main_count)
  );

  lms_align_fifo #(.WIDTH(AUX_W), .AW(FIFO_AW)) u_aux_fifo (
    .i_clk      (axis_data_clk),
    .i_rst      (axis_data_rst),
    .i_wr_data  ({s_aux_axis.tdata, s_aux_axis.tlast}),
    .i_wr_valid (s_aux_axis.tvalid),
    .o_wr_ready (s_aux_axis.tready),
    .o_rd_data  (w_aux_head),
    .i_rd_pop   (w_pop_aux),
    .o_empty    (w_aux_empty),
    .o_full     (w_aux_full),
    .o_count    (w_aux_count)
  );

  assign {w_main_data, w_main_last, w_ts, w_has_time, w_len, w_eov, w_eob} = w_main_head;
  assign {w_aux_data, w_aux_last} = w_aux_head;
  assign w_fire = w_valid & m_pair_axis.tready;

  // aux sideband is deliberately dropped; fill levels are not needed here
  assign w_unused_sigs = ^{w_main_full, w_aux_full, w_main_count, w_aux_count,
                           s_aux_axis.ttimestamp, s_aux_axis.thas_time, s_aux_axis.tlength,
                           s_aux_axis.teov, s_aux_axis.teob};

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) r_state <= ST_PAIR;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_pop_main  = 1'b0;
    w_pop_aux   = 1'b0;
    w_inc       = 1'b0;
    w_pad       = 1'b0;
    w_aux_half  = w_aux_data;
    case (r_state)
      ST_PAIR: begin
        w_valid = ~w_main_empty & ~w_aux_empty;
        if (w_fire) begin
          w_pop_main = 1'b1;
          w_pop_aux  = 1'b1;
          if (w_main_last & ~w_aux_last) begin
            w_inc       = 1'b1;
            w_state_nxt = ST_DISCARD_AUX;
          end else if (~w_main_last & w_aux_last) begin
            w_inc       = 1'b1;
            w_state_nxt = ST_PAD_MAIN;
          end
        end
      end
      ST_DISCARD_AUX: begin
        if (~w_aux_empty) begin
          w_pop_aux = 1'b1;
          if (w_aux_last) w_state_nxt = ST_PAIR;
        end
      end
      ST_PAD_MAIN: begin
        w_pad      = 1'b1;
        w_aux_half = '0;
        w_valid    = ~w_main_empty;
        if (w_fire) begin
          w_pop_main = 1'b1;
          if (w_main_last) w_state_nxt = ST_PAIR;
        end
      end
      default: w_state_nxt = ST_PAIR;
    endcase
  end

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst)  r_mismatch_cnt <= 16'd0;
    else if (clear_cnt) r_mismatch_cnt <= 16'd0;
    else if (w_inc)     r_mismatch_cnt <= sat_inc16(r_mismatch_cnt);
  end

  assign m_pair_axis.tdata      = {w_aux_half, w_main_data};
  assign m_pair_axis.tlast      = w_main_last;
  assign m_pair_axis.tvalid     = w_valid;
  assign m_pair_axis.ttimestamp = w_ts;
  assign m_pair_axis.thas_time  = w_has_time;
  assign m_pair_axis.tlength    = w_len;
  assign m_pair_axis.teov       = w_eov;
  assign m_pair_axis.teob       = w_eob;
  assign mismatch_cnt           = r_mismatch_cnt;
  assign pad_active             = w_pad;

endmodule

// File: tb/tb_lms_input_align.sv
// tb/tb_lms_input_align.sv - directed self-checking bench for lms_input_align
module tb_lms_input_align;
  import lms_input_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_cnt = 1'b0;
  logic [15:0] mismatch_cnt;
  logic        pad_active;

  lms_input_align_if #(.DATA_W(32)) main_if ();
  lms_input_align_if #(.DATA_W(32)) aux_if ();
  lms_input_align_if #(.DATA_W(64)) pair_if ();

  lms_input_align #(.SAMP_W(32), .FIFO_AW(4)) dut (
    .axis_data_clk (clk),
    .axis_data_rst (rst),
    .s_main_axis   (main_if),
    .s_aux_axis    (aux_if),
    .m_pair_axis   (pair_if),
    .clear_cnt     (clear_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .pad_active    (pad_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [63:0] ts;
  } in_t;

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic [63:0] ts;
    logic        eob;
    logic        pad;
    int          cyc;
  } out_t;

  in_t  main_q[$];
  in_t  aux_q[$];
  out_t out_q[$];
  out_t exp_q[$];
  bit   main_en = 1'b1;
  bit   aux_en  = 1'b1;
  int   main_acc = 0;
  int   pair_mode = 1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin : main_drv
    bit fire;
    main_if.tvalid = 1'b0; main_if.tdata = '0; main_if.tlast = 1'b0;
    main_if.ttimestamp = '0; main_if.thas_time = 1'b0; main_if.tlength = '0;
    main_if.teov = 1'b0; main_if.teob = 1'b0;
    forever begin
      @(negedge clk);
      fire = main_if.tvalid && main_if.tready;
      @(posedge clk); #1;
      if (fire) begin
        if (main_q.size() > 0) void'(main_q.pop_front());
        main_acc++;
      end
      if (main_en && main_q.size() > 0) begin
        main_if.tdata      = main_q[0].d;
        main_if.tlast      = main_q[0].last;
        main_if.ttimestamp = main_q[0].ts;
        main_if.thas_time  = 1'b1;
        main_if.tlength    = 16'd8;
        main_if.teob       = main_q[0].last;
        main_if.tvalid     = 1'b1;
      end else begin
        main_if.tvalid = 1'b0;
      end
    end
  end

  initial begin : aux_drv
    bit fire;
    aux_if.tvalid = 1'b0; aux_if.tdata = '0; aux_if.tlast = 1'b0;
    aux_if.ttimestamp = '0; aux_if.thas_time = 1'b0; aux_if.tlength = '0;
    aux_if.teov = 1'b0; aux_if.teob = 1'b0;
    forever begin
      @(negedge clk);
      fire = aux_if.tvalid && aux_if.tready;
      @(posedge clk); #1;
      if (fire && aux_q.size() > 0) void'(aux_q.pop_front());
      if (aux_en && aux_q.size() > 0) begin
        aux_if.tdata  = aux_q[0].d;
        aux_if.tlast  = aux_q[0].last;
        aux_if.tvalid = 1'b1;
      end else begin
        aux_if.tvalid = 1'b0;
      end
    end
  end

  initial begin : pair_rdy
    pair_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pair_mode == 1)      pair_if.tready = 1'b1;
      else if (pair_mode == 2) pair_if.tready = 1'($urandom_range(0, 1));
    end
  end

  // collects transfers and checks the output holds while stalled
  initial begin : mon
    bit   prev_stall;
    out_t cur, prev;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cur.d = pair_if.tdata; cur.last = pair_if.tlast; cur.ts = pair_if.ttimestamp;
      cur.eob = pair_if.teob; cur.pad = pad_active; cur.cyc = cyc;
      if (prev_stall && !rst) begin
        chk("stall_valid", pair_if.tvalid, 1'b1);
        chk("stall_data", cur.d, prev.d);
        chk("stall_ts", cur.ts, prev.ts);
        chk("stall_last", cur.last, prev.last);
      end
      if (pair_if.tvalid && pair_if.tready && !rst) out_q.push_back(cur);
      prev_stall = pair_if.tvalid && !pair_if.tready && !rst;
      prev = cur;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_main(input logic [31:0] d, input logic last, input logic [63:0] ts);
    main_q.push_back({d, last, ts});
  endtask

  task automatic push_aux(input logic [31:0] d, input logic last);
    aux_q.push_back({d, last, 64'd0});
  endtask

  task automatic exp_pair(input logic [31:0] a, input logic [31:0] m, input logic l,
                          input logic [63:0] ts, input logic p);
    out_t e;
    e.d = {a, m}; e.last = l; e.ts = ts; e.eob = l; e.pad = p; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_cnt = 1'b1;
    @(posedge clk); #1 clear_cnt = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int t;
    t = 0;
    while (out_q.size() < exp_q.size() && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("%s.count", tag), out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s[%0d].data", tag, i), out_q[i].d, exp_q[i].d);
      chk($sformatf("%s[%0d].last", tag, i), out_q[i].last, exp_q[i].last);
      chk($sformatf("%s[%0d].ts", tag, i), out_q[i].ts, exp_q[i].ts);
      chk($sformatf("%s[%0d].eob", tag, i), out_q[i].eob, exp_q[i].eob);
      chk($sformatf("%s[%0d].pad", tag, i), out_q[i].pad, exp_q[i].pad);
    end
  endtask

  initial begin : stim
    int t;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.main_ready", main_if.tready, 1'b0);
    chk("rst.aux_ready", aux_if.tready, 1'b0);
    chk("rst.pair_valid", pair_if.tvalid, 1'b0);
    chk("rst.mismatch", mismatch_cnt, 16'd0);
    chk("rst.pad", pad_active, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst.main_ready", main_if.tready, 1'b1);
    chk("post_rst.aux_ready", aux_if.tready, 1'b1);

    // two matched 8-beat packets at full rate
    flush();
    for (int n = 1; n <= 16; n++) begin
      push_main(32'(n), (n % 8) == 0, 64'(n));
      push_aux(32'h1000 + 32'(n), (n % 8) == 0);
      exp_pair(32'h1000 + 32'(n), 32'(n), (n % 8) == 0, 64'(n), 1'b0);
    end
    check_out("t1");
    if (out_q.size() == 16) chk("t1.rate", out_q[15].cyc - out_q[0].cyc, 15);
    chk("t1.mismatch", mismatch_cnt, 16'd0);

    // short main packet: aux tail discarded
    flush();
    pulse_clear();
    for (int k = 0; k < 4; k++) push_main(32'd100 + 32'(k), k == 3, 64'd100 + 64'(k));
    for (int k = 0; k < 4; k++) push_main(32'd110 + 32'(k), k == 3, 64'd110 + 64'(k));
    for (int k = 0; k < 6; k++) push_aux(32'h2000 + 32'(k), k == 5);
    for (int k = 0; k < 4; k++) push_aux(32'h2010 + 32'(k), k == 3);
    for (int k = 0; k < 4; k++) exp_pair(32'h2000 + 32'(k), 32'd100 + 32'(k), k == 3, 64'd100 + 64'(k), 1'b0);
    for (int k = 0; k < 4; k++) exp_pair(32'h2010 + 32'(k), 32'd110 + 32'(k), k == 3, 64'd110 + 64'(k), 1'b0);
    check_out("t2");
    chk("t2.mismatch", mismatch_cnt, 16'd1);

    // short aux packet: main tail padded
    flush();
    pulse_clear();
    for (int k = 0; k < 6; k++) push_main(32'd200 + 32'(k), k == 5, 64'd200 + 64'(k));
    for (int k = 0; k < 2; k++) push_main(32'd210 + 32'(k), k == 1, 64'd210 + 64'(k));
    for (int k = 0; k < 4; k++) push_aux(32'h3000 + 32'(k), k == 3);
    for (int k = 0; k < 2; k++) push_aux(32'h3010 + 32'(k), k == 1);
    for (int k = 0; k < 4; k++) exp_pair(32'h3000 + 32'(k), 32'd200 + 32'(k), 1'b0, 64'd200 + 64'(k), 1'b0);
    exp_pair(32'h0, 32'd204, 1'b0, 64'd204, 1'b1);
    exp_pair(32'h0, 32'd205, 1'b1, 64'd205, 1'b1);
    for (int k = 0; k < 2; k++) exp_pair(32'h3010 + 32'(k), 32'd210 + 32'(k), k == 1, 64'd210 + 64'(k), 1'b0);
    check_out("t3");
    chk("t3.mismatch", mismatch_cnt, 16'd1);

    // aux absent: main backpressures after 16 beats, nothing dropped
    flush();
    pulse_clear();
    aux_en = 1'b0;
    main_acc = 0;
    for (int k = 0; k < 20; k++) push_main(32'd300 + 32'(k), k == 19, 64'd300 + 64'(k));
    repeat (30) @(negedge clk);
    chk("t4.main_ready", main_if.tready, 1'b0);
    chk("t4.accepted", main_acc, 16);
    chk("t4.pair_valid", pair_if.tvalid, 1'b0);
    for (int k = 0; k < 20; k++) begin
      push_aux(32'h4000 + 32'(k), k == 19);
      exp_pair(32'h4000 + 32'(k), 32'd300 + 32'(k), k == 19, 64'd300 + 64'(k), 1'b0);
    end
    aux_en = 1'b1;
    check_out("t4");
    chk("t4.mismatch", mismatch_cnt, 16'd0);

    // random output backpressure, timestamp carried through
    flush();
    pair_mode = 2;
    for (int k = 0; k < 10; k++) begin
      push_main(32'd500 + 32'(k), k == 9, (k == 3) ? 64'h1234 : 64'd500 + 64'(k));
      push_aux(32'h5000 + 32'(k), k == 9);
      exp_pair(32'h5000 + 32'(k), 32'd500 + 32'(k), k == 9, (k == 3) ? 64'h1234 : 64'd500 + 64'(k), 1'b0);
    end
    check_out("t5");
    @(posedge clk); #1 pair_mode = 1;

    // saturation at 0xFFFF
    flush();
    @(negedge clk);
    force dut.r_mismatch_cnt = 16'hFFFF;
    #1 release dut.r_mismatch_cnt;
    @(negedge clk);
    chk("t6.forced", mismatch_cnt, 16'hFFFF);
    push_main(32'd600, 1'b1, 64'd600);
    push_aux(32'h6000, 1'b0);
    push_aux(32'h6001, 1'b1);
    exp_pair(32'h6000, 32'd600, 1'b1, 64'd600, 1'b0);
    check_out("t6");
    chk("t6.saturated", mismatch_cnt, 16'hFFFF);

    // clear in the same cycle as a mismatch wins
    flush();
    @(posedge clk); #1;
    pair_mode = 0;
    pair_if.tready = 1'b0;
    push_main(32'd610, 1'b1, 64'd610);
    push_aux(32'h6100, 1'b0);
    push_aux(32'h6101, 1'b1);
    exp_pair(32'h6100, 32'd610, 1'b1, 64'd610, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!pair_if.tvalid && t < 50);
    chk("t6b.valid_seen", pair_if.tvalid, 1'b1);
    @(posedge clk); #1;
    pair_if.tready = 1'b1;
    clear_cnt = 1'b1;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
    pair_mode = 1;
    @(negedge clk);
    chk("t6b.clear_wins", mismatch_cnt, 16'd0);
    check_out("t6b");

    // reset mid-packet while padding with aux beats buffered
    flush();
    pulse_clear();
    for (int k = 0; k < 3; k++) push_main(32'd700 + 32'(k), 1'b0, 64'd700 + 64'(k));
    push_aux(32'h7000, 1'b1);
    push_aux(32'h7100, 1'b0);
    push_aux(32'h7101, 1'b0);
    exp_pair(32'h7000, 32'd700, 1'b0, 64'd700, 1'b0);
    exp_pair(32'h0, 32'd701, 1'b0, 64'd701, 1'b1);
    exp_pair(32'h0, 32'd702, 1'b0, 64'd702, 1'b1);
    check_out("t7");
    chk("t7.pad_active", pad_active, 1'b1);
    chk("t7.mismatch", mismatch_cnt, 16'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t7.rst_pad", pad_active, 1'b0);
    chk("t7.rst_valid", pair_if.tvalid, 1'b0);
    chk("t7.rst_mismatch", mismatch_cnt, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    flush();
    push_main(32'd800, 1'b1, 64'd800);
    push_aux(32'h8000, 1'b1);
    exp_pair(32'h8000, 32'd800, 1'b1, 64'd800, 1'b0);
    check_out("t7b");
    chk("t7b.mismatch", mismatch_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
